// File: rtl/wifi_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wifi_rx_pkg
//  Description : Shared constants and types for the 802.11 receive datapath.
//                SERVICE field length, PSDU length width, descrambler FSM
//                state encoding, LFSR tap positions and seed length.
//  Revision    : 1.0  initial release
// ============================================================================
package wifi_rx_pkg;

    // SERVICE field length in bits (first bits after the SIGNAL field).
    localparam int C_SERVICE_BITS = 16;
    // Width of the PSDU byte-length input.
    localparam int C_LEN_W        = 12;

    // x^7 + x^4 + 1 scrambler: feedback taps at state bits 6 and 3.
    localparam int C_LFSR_W       = 7;
    localparam int C_TAP_HI       = 6;
    localparam int C_TAP_LO       = 3;
    // The first SEED_LEN received bits seed the descrambler state.
    localparam int C_SEED_LEN     = 7;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEED    = 3'd1,
        ST_SERVICE = 3'd2,
        ST_DATA    = 3'd3,
        ST_DRAIN   = 3'd4
    } fsm_state_t;

endpackage : wifi_rx_pkg
`default_nettype wire

// File: rtl/scrambler_lfsr7.sv
`default_nettype none
// ============================================================================
//  Module      : scrambler_lfsr7
//  Description : 7-bit 802.11 scrambler state register.
//                i_clear    : synchronous clear to zero
//                i_shift_in : state <= {state[5:0], i_bit}  (seeding)
//                i_advance  : state <= {state[5:0], o_fb}   (free-running)
//                o_fb       : state[6] ^ state[3]
//                rst_n      : synchronous active-low reset
//  Revision    : 1.0  initial release
// ============================================================================
module scrambler_lfsr7
    import wifi_rx_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_shift_in,
    input  logic i_advance,
    input  logic i_bit,
    output logic o_fb
);

    logic [C_LFSR_W-1:0] r_state;
    logic                w_fb;

    assign w_fb = r_state[C_TAP_HI] ^ r_state[C_TAP_LO];
    assign o_fb = w_fb;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_state <= '0;
        end else if (i_shift_in) begin
            r_state <= {r_state[C_LFSR_W-2:0], i_bit};
        end else if (i_advance) begin
            r_state <= {r_state[C_LFSR_W-2:0], w_fb};
        end
    end

endmodule : scrambler_lfsr7
`default_nettype wire

// File: rtl/descrambler_wifi.sv
`default_nettype none
// ============================================================================
//  Module      : descrambler_wifi
//  Description : 802.11 self-synchronising-seed descrambler. Seeds the LFSR
//                from the first 7 received bits, descrambles and checks the
//                rest of the SERVICE field, then packs PSDU bits LSB-first
//                into bytes.
//  Ports       : clk, rst_n (sync, active-low)
//                i_start      - one-cycle frame start, samples i_psdu_len
//                i_psdu_len   - PSDU length in bytes
//                i_bit_in     - decoded bit, qualified by i_bit_valid
//                o_data_out   - descrambled byte (held between pulses)
//                o_data_valid - one-cycle byte strobe
//                o_frame_done - one-cycle end-of-frame strobe
//                o_service_err- sticky nonzero-SERVICE-bit flag
//                o_busy       - frame in progress (SEED/SERVICE/DATA)
//  Revision    : 1.0  initial release
// ============================================================================
module descrambler_wifi
    import wifi_rx_pkg::*;
#(
    parameter int SERVICE_BITS = C_SERVICE_BITS,
    parameter int LEN_W        = C_LEN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_psdu_len,
    input  logic             i_bit_in,
    input  logic             i_bit_valid,
    output logic [7:0]       o_data_out,
    output logic             o_data_valid,
    output logic             o_frame_done,
    output logic             o_service_err,
    output logic             o_busy
);

    localparam int            SC_W      = $clog2(SERVICE_BITS + 1);
    localparam logic [SC_W-1:0] SEED_LAST = SC_W'(C_SEED_LEN - 1);
    localparam logic [SC_W-1:0] SVC_LAST  = SC_W'(SERVICE_BITS - 1);

    fsm_state_t       r_state;
    logic [LEN_W-1:0] r_len;
    logic [SC_W-1:0]  r_svc_cnt;   // counts seed + SERVICE bits
    logic [2:0]       r_bit_cnt;   // bit position within current byte
    logic [LEN_W-1:0] r_byte_cnt;
    logic [6:0]       r_shreg;     // first 7 bits of the byte being packed
    logic [7:0]       r_data_out;
    logic             r_data_valid;
    logic             r_frame_done;
    logic             r_service_err;

    logic w_take;
    logic w_shift_in;
    logic w_advance;
    logic w_fb;
    logic w_out;

    // start wins over a coincident bit: that bit is never consumed.
    assign w_take     = i_bit_valid && !i_start;
    assign w_shift_in = w_take && (r_state == ST_SEED);
    assign w_advance  = w_take && ((r_state == ST_SERVICE) || (r_state == ST_DATA));
    assign w_out      = i_bit_in ^ w_fb;

    scrambler_lfsr7 u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (i_start),
        .i_shift_in (w_shift_in),
        .i_advance  (w_advance),
        .i_bit      (i_bit_in),
        .o_fb       (w_fb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_len         <= '0;
            r_svc_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_byte_cnt    <= '0;
            r_shreg       <= '0;
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
            r_frame_done  <= 1'b0;
            r_service_err <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_frame_done <= 1'b0;
            if (i_start) begin
                // Abort whatever was in progress; partial bytes are dropped.
                r_state       <= ST_SEED;
                r_len         <= i_psdu_len;
                r_svc_cnt     <= '0;
                r_bit_cnt     <= '0;
                r_byte_cnt    <= '0;
                r_service_err <= 1'b0;
            end else if (i_bit_valid) begin
                case (r_state)
                    ST_SEED: begin
                        r_svc_cnt <= r_svc_cnt + 1'b1;
                        if (r_svc_cnt == SEED_LAST) begin
                            r_state <= ST_SERVICE;
                        end
                    end
                    ST_SERVICE: begin
                        r_svc_cnt <= r_svc_cnt + 1'b1;
                        if (w_out) begin
                            r_service_err <= 1'b1;
                        end
                        if (r_svc_cnt == SVC_LAST) begin
                            if (r_len == '0) begin
                                r_state      <= ST_DRAIN;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_state <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        r_shreg   <= {w_out, r_shreg[6:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            r_data_out   <= {w_out, r_shreg};
                            r_data_valid <= 1'b1;
                            r_byte_cnt   <= r_byte_cnt + 1'b1;
                            if (r_byte_cnt == r_len - 1'b1) begin
                                r_state      <= ST_DRAIN;
                                r_frame_done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        // IDLE and DRAIN ignore incoming bits.
                    end
                endcase
            end
        end
    end

    assign o_data_out    = r_data_out;
    assign o_data_valid  = r_data_valid;
    assign o_frame_done  = r_frame_done;
    assign o_service_err = r_service_err;
    assign o_busy        = (r_state == ST_SEED) || (r_state == ST_SERVICE) ||
                           (r_state == ST_DATA);

endmodule : descrambler_wifi
`default_nettype wire

// File: tb/tb_descrambler_wifi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_descrambler_wifi
//  Description : Scoreboard bench for descrambler_wifi. Frames are built from
//                known plaintext, scrambled with the 802.11 scrambler and fed
//                bit by bit; expected bytes and strobe cycles are queued and a
//                monitor checks every DUT strobe against the queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_descrambler_wifi;

    localparam int LEN_W = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_start;
    logic [LEN_W-1:0] i_psdu_len;
    logic             i_bit_in;
    logic             i_bit_valid;
    logic [7:0]       o_data_out;
    logic             o_data_valid;
    logic             o_frame_done;
    logic             o_service_err;
    logic             o_busy;

    always #5 clk = ~clk;

    descrambler_wifi #(.SERVICE_BITS(16), .LEN_W(LEN_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (i_start),
        .i_psdu_len    (i_psdu_len),
        .i_bit_in      (i_bit_in),
        .i_bit_valid   (i_bit_valid),
        .o_data_out    (o_data_out),
        .o_data_valid  (o_data_valid),
        .o_frame_done  (o_frame_done),
        .o_service_err (o_service_err),
        .o_busy        (o_busy)
    );

    typedef struct packed {
        logic        is_byte;
        logic [7:0]  data;
        logic        done;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (o_data_valid || o_frame_done) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got valid=%0b done=%0b data=%02h expected none",
                         o_data_valid, o_frame_done, o_data_out);
            end else begin
                mon_e = sbq.pop_front();
                chk("data_valid", {31'd0, o_data_valid}, {31'd0, mon_e.is_byte});
                if (mon_e.is_byte) chk("data_out", {24'd0, o_data_out}, {24'd0, mon_e.data});
                chk("frame_done", {31'd0, o_frame_done}, {31'd0, mon_e.done});
                chk("strobe_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic start_frame(input logic [LEN_W-1:0] len, input logic with_bit, input logic b);
        i_start     = 1'b1;
        i_psdu_len  = len;
        i_bit_valid = with_bit;
        i_bit_in    = b;
        @(negedge clk);
        i_start     = 1'b0;
        i_bit_valid = 1'b0;
    endtask

    // Scramble 16 SERVICE bits + len bytes (LSB first) + tail and drive them.
    // flip: SERVICE bit index forced to 1 (-1 none); nmax: stop early (-1 none).
    task automatic send_frame(input logic [6:0] seed, input int len, input logic [7:0] b0,
                              input logic [7:0] b1, input int flip, input int gap,
                              input int nmax, input int tail);
        logic [6:0] st;
        logic       pb, fb, sb;
        logic [7:0] cur;
        int         n, k;
        st = seed;
        n  = 16 + 8 * len + tail;
        if (nmax >= 0 && nmax < n) n = nmax;
        for (int i = 0; i < n; i++) begin
            pb  = 1'b0;
            cur = 8'h00;
            if (i == flip) pb = 1'b1;
            else if (i >= 16 && i < 16 + 8 * len) begin
                k   = i - 16;
                cur = (k < 8) ? b0 : b1;
                pb  = cur[k % 8];
            end else if (i >= 16 + 8 * len) pb = 1'($urandom_range(0, 1));
            fb = st[6] ^ st[3];
            sb = pb ^ fb;
            st = {st[5:0], fb};
            repeat (gap) @(negedge clk);
            i_bit_in    = sb;
            i_bit_valid = 1'b1;
            if (len == 0 && i == 15) sbq.push_back({1'b0, 8'h00, 1'b1, cyc + 32'd1});
            if (i >= 16 && i < 16 + 8 * len && ((i - 16) % 8) == 7)
                sbq.push_back({1'b1, cur, ((i - 16) / 8) == (len - 1), cyc + 32'd1});
            @(negedge clk);
            i_bit_valid = 1'b0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_data_out"},    {24'd0, o_data_out}, 32'd0);
        chk({tag, "_data_valid"},  {31'd0, o_data_valid}, 32'd0);
        chk({tag, "_frame_done"},  {31'd0, o_frame_done}, 32'd0);
        chk({tag, "_service_err"}, {31'd0, o_service_err}, 32'd0);
        chk({tag, "_busy"},        {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_psdu_len  = '0;
        i_bit_in    = 1'b0;
        i_bit_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Contiguous frame: 0x00, 0xA5.
        start_frame(12'd2, 1'b0, 1'b0);
        chk("busy_after_start", {31'd0, o_busy}, 32'd1);
        send_frame(7'b1011101, 2, 8'h00, 8'hA5, -1, 0, -1, 6);
        chk("svc_err_clean", {31'd0, o_service_err}, 32'd0);
        chk("busy_drain", {31'd0, o_busy}, 32'd0);

        // Same frame, bit_valid one cycle in three.
        start_frame(12'd2, 1'b0, 1'b0);
        send_frame(7'b1011101, 2, 8'h00, 8'hA5, -1, 2, -1, 3);
        chk("svc_err_gappy", {31'd0, o_service_err}, 32'd0);

        // Zero-length PSDU with 10 trailing bits.
        start_frame(12'd0, 1'b0, 1'b0);
        send_frame(7'b1011101, 0, 8'h00, 8'h00, -1, 0, -1, 10);
        chk("svc_err_len0", {31'd0, o_service_err}, 32'd0);
        chk("busy_len0", {31'd0, o_busy}, 32'd0);

        // SERVICE bit 9 corrupted.
        start_frame(12'd2, 1'b0, 1'b0);
        send_frame(7'b1011101, 2, 8'h00, 8'hA5, 9, 0, -1, 4);
        chk("svc_err_set", {31'd0, o_service_err}, 32'd1);
        repeat (3) @(negedge clk);
        chk("svc_err_sticky", {31'd0, o_service_err}, 32'd1);

        // Abort after 5 bits of byte 1, restart with a coincident dropped bit.
        start_frame(12'd2, 1'b0, 1'b0);
        chk("svc_err_cleared", {31'd0, o_service_err}, 32'd0);
        send_frame(7'b1011101, 2, 8'h00, 8'hA5, -1, 0, 21, 0);
        start_frame(12'd1, 1'b1, 1'b1);
        send_frame(7'b0110011, 1, 8'h3C, 8'h00, -1, 0, -1, 4);
        chk("svc_err_restart", {31'd0, o_service_err}, 32'd0);

        // Reset held 3 cycles mid-frame, then a clean frame.
        start_frame(12'd2, 1'b0, 1'b0);
        send_frame(7'b1011101, 2, 8'h00, 8'hA5, -1, 0, 12, 0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("midrst");
        rst_n = 1'b1;
        @(negedge clk);
        start_frame(12'd1, 1'b0, 1'b0);
        send_frame(7'b1100101, 1, 8'h3C, 8'h00, -1, 1, -1, 2);

        repeat (5) @(negedge clk);
        chk("queue_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_descrambler_wifi
`default_nettype wire
